// File: rtl/pwm_gen.sv
// PWM generator with a one-deep configuration buffer.
// New duty/period values only take effect in IDLE or on the period wrap edge.
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [WIDTH-1:0] cfg_period,
    output logic             pwm,
    output logic             cycle_end
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_a;
    logic [WIDTH-1:0] per_a;
    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] pend_per;
    logic             pend_valid;

    logic accept;
    logic wrap;
    logic apply;

    assign cfg_ready = !pend_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign wrap      = (state == RUN) && (cnt == per_a);

    // accept and apply are mutually exclusive: accept needs pend_valid=0, apply needs pend_valid=1,
    // so a value offered on the wrap edge lands in pending and waits for the following wrap.
    always_comb begin
        apply = 1'b0;
        if (pend_valid) begin
            if (state == IDLE)
                apply = 1'b1;
            else if (en && wrap)
                apply = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            duty_a     <= '0;
            per_a      <= '1;
            pend_duty  <= '0;
            pend_per   <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (apply) begin
                duty_a <= pend_duty;
                per_a  <= pend_per;
            end

            if (accept) begin
                pend_duty  <= cfg_duty;
                pend_per   <= cfg_period;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en)
                        state <= RUN;
                end
                default: begin
                    if (!en) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == per_a) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pwm       = (state == RUN) && (cnt < duty_a);
    assign cycle_end = wrap;

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of the counter, duty and period values.
REQ-002 The block SHALL have port ck, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: run enable.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-007 The block SHALL have port cfg_duty, input, WIDTH bits: requested high-time in ck cycles.
REQ-008 The block SHALL have port cfg_period, input, WIDTH bits: requested period minus 1, in ck cycles.
REQ-009 The block SHALL have port pwm, output, 1 bit: PWM waveform, consumed by the downstream output flip-flop stage.
REQ-010 The block SHALL have port cycle_end, output, 1 bit: one-cycle pulse on the last cycle of each period.

Function
REQ-011 The block SHALL hold internal registers state (IDLE/RUN), cnt, duty_a, per_a (active values), and a one-deep pending buffer pend_duty/pend_per/pend_valid.
REQ-012 The block SHALL drive cfg_ready = !pend_valid, combinationally.
REQ-013 On an edge with cfg_valid && cfg_ready, the block SHALL capture cfg_duty/cfg_period into pending and set pend_valid.
REQ-014 In IDLE with pend_valid=1, the block SHALL copy pending into duty_a/per_a and clear pend_valid on the next edge.
REQ-015 In RUN, the block SHALL apply pending only on the wrap edge (cnt==per_a); the period never changes mid-cycle.
REQ-016 If acceptance and wrap occur on the same edge, the new value SHALL go to pending and take effect at the following wrap.
REQ-017 In IDLE with en=1, the block SHALL go to RUN with cnt=0; a pending value is applied on that same edge.
REQ-018 In RUN, cnt SHALL increment by 1 each cycle and wrap to 0 after reaching per_a, giving a period of per_a+1 cycles.
REQ-019 In RUN with en=0, the block SHALL go to IDLE and set cnt=0 on the next edge; the pending buffer is retained.
REQ-020 The block SHALL drive pwm = (state==RUN) && (cnt < duty_a), decoded only from registers, never from inputs.
REQ-021 For boundary values, pwm SHALL be: duty_a=0 constant 0; duty_a > per_a constant 1 while RUN.
REQ-022 For per_a=0, cnt SHALL stay 0, the period SHALL be 1 cycle, and cycle_end SHALL be high every RUN cycle.
REQ-023 The block SHALL drive cycle_end = (state==RUN) && (cnt==per_a); it is 0 in IDLE.
REQ-024 All WIDTH-bit comparisons SHALL be unsigned, and cnt SHALL never exceed per_a.

Reset
REQ-025 On an edge with rst=1, the block SHALL set state=IDLE, cnt=0, duty_a=0, per_a=all-ones, and pend_valid=0; rst overrides all other inputs.
REQ-026 During and immediately after reset, outputs SHALL be pwm=0, cycle_end=0, and cfg_ready=1.
REQ-027 Reset asserted mid-period SHALL discard any pending configuration, and the block SHALL restart from IDLE.

Verification (WIDTH=8)
REQ-028 Bench SHALL check: reset; cfg duty=3, period=9; en=1 -> pwm repeats 3 cycles high, 7 low; cycle_end high at cnt=9 only.
REQ-029 Bench SHALL check: duty=0, period=9 -> pwm constant 0; duty=10, period=9 -> pwm constant 1; cycle_end still every 10 cycles.
REQ-030 Bench SHALL check: running 3/9, offer duty=7 at cnt=4 -> accepted, cfg_ready low until wrap, 7 high from next cnt=0.
REQ-031 Bench SHALL check: offer duty=5 on the wrap cycle -> old duty for one more full period, then 5; cfg_ready low for that period.
REQ-032 Bench SHALL check: en drops at cnt=5 -> next cycle pwm=0, cnt=0, IDLE; en=1 restarts a full period from cnt=0.
REQ-033 Bench SHALL check: rst at cnt=6 with pend_valid=1 -> next cycle pwm=0, cycle_end=0, cfg_ready=1, per_a=255, duty_a=0.
